// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes and flag bit positions shared by the ALU slice
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_INC = 4'h2;
    localparam logic [3:0] OP_DEC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SL  = 4'h8;
    localparam logic [3:0] OP_SR  = 4'h9;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// alu_if : operand/result bundle between a datapath and an ALU slice
// Revision: 1.0
// ============================================================================
interface alu_if #(
    parameter int bits = 4
);
    logic [bits-1:0] ALUA;
    logic [bits-1:0] ALUB;
    logic            ALUFlagIn;
    logic [bits-1:0] ALUResult;
    logic [3:0]      ALUFlags;

    modport master (
        output ALUA, ALUB, ALUFlagIn,
        input  ALUResult, ALUFlags
    );

    modport slave (
        input  ALUA, ALUB, ALUFlagIn,
        output ALUResult, ALUFlags
    );
endinterface : alu_if
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// alu_shifter : logical left / arithmetic right shift with last-bit-out carry
// Revision: 1.0
// ============================================================================
module alu_shifter #(
    parameter int bits  = 4,
    parameter bit RIGHT = 1'b0
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] amt,
    output logic [bits-1:0] result,
    output logic            carry
);

    // One guard bit beside the operand catches the last bit shifted out;
    // oversized amounts fall out naturally as zero / sign fill.
    generate
        if (RIGHT) begin : g_right
            logic signed [bits:0] w_ext;
            assign w_ext  = $signed({a, 1'b0}) >>> amt;
            assign result = w_ext[bits:1];
            assign carry  = w_ext[0];
        end else begin : g_left
            logic [bits:0] w_ext;
            assign w_ext  = {1'b0, a} << amt;
            assign result = w_ext[bits-1:0];
            assign carry  = w_ext[bits];
        end
    endgenerate

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// alu_unit : fixed-function ALU slice, operation chosen at elaboration
// Revision: 1.0
// ============================================================================
module alu_unit
    import alu_pkg::*;
#(
    parameter int         bits       = 4,
    parameter logic [3:0] ALUControl = 4'h0
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus
);

    localparam logic [bits-1:0] c_one     = {{(bits-1){1'b0}}, 1'b1};
    localparam logic [bits-1:0] c_max_pos = {1'b0, {(bits-1){1'b1}}};
    localparam logic [bits-1:0] c_min_neg = {1'b1, {(bits-1){1'b0}}};
    localparam int              c_msb     = bits - 1;

    logic [bits-1:0] w_result;
    logic            w_c;
    logic            w_v;
    logic [3:0]      w_flags;
    logic [bits-1:0] r_result;
    logic [3:0]      r_flags;
    logic            w_unused_inputs;

    assign w_unused_inputs = ^{bus.ALUA, bus.ALUB, bus.ALUFlagIn};

    generate
        case (ALUControl)
            OP_ADD: begin : g_add
                logic [bits:0] w_sum;
                assign w_sum    = {1'b0, bus.ALUA} + {1'b0, bus.ALUB}
                                + {{bits{1'b0}}, bus.ALUFlagIn};
                assign w_result = w_sum[bits-1:0];
                assign w_c      = w_sum[bits];
                assign w_v      = (bus.ALUA[c_msb] == bus.ALUB[c_msb])
                               && (w_sum[c_msb] != bus.ALUA[c_msb]);
            end
            OP_SUB: begin : g_sub
                logic [bits:0] w_diff;
                // Top bit of the widened difference is the borrow.
                assign w_diff   = {1'b0, bus.ALUA} - {1'b0, bus.ALUB}
                                - {{bits{1'b0}}, bus.ALUFlagIn};
                assign w_result = w_diff[bits-1:0];
                assign w_c      = w_diff[bits];
                assign w_v      = (bus.ALUA[c_msb] != bus.ALUB[c_msb])
                               && (w_diff[c_msb] != bus.ALUA[c_msb]);
            end
            OP_INC: begin : g_inc
                assign w_result = bus.ALUA + c_one;
                assign w_c      = &bus.ALUA;
                assign w_v      = (bus.ALUA == c_max_pos);
            end
            OP_DEC: begin : g_dec
                assign w_result = bus.ALUA - c_one;
                assign w_c      = ~|bus.ALUA;
                assign w_v      = (bus.ALUA == c_min_neg);
            end
            OP_AND: begin : g_and
                assign w_result = bus.ALUA & bus.ALUB;
                assign w_c      = 1'b0;
                assign w_v      = 1'b0;
            end
            OP_OR: begin : g_or
                assign w_result = bus.ALUA | bus.ALUB;
                assign w_c      = 1'b0;
                assign w_v      = 1'b0;
            end
            OP_NOT: begin : g_not
                assign w_result = ~bus.ALUA;
                assign w_c      = 1'b0;
                assign w_v      = 1'b0;
            end
            OP_XOR: begin : g_xor
                assign w_result = bus.ALUA ^ bus.ALUB;
                assign w_c      = 1'b0;
                assign w_v      = 1'b0;
            end
            OP_SL: begin : g_sl
                alu_shifter #(.bits(bits), .RIGHT(1'b0)) u_shifter (
                    .a      (bus.ALUA),
                    .amt    (bus.ALUB),
                    .result (w_result),
                    .carry  (w_c)
                );
                assign w_v = 1'b0;
            end
            OP_SR: begin : g_sr
                alu_shifter #(.bits(bits), .RIGHT(1'b1)) u_shifter (
                    .a      (bus.ALUA),
                    .amt    (bus.ALUB),
                    .result (w_result),
                    .carry  (w_c)
                );
                assign w_v = 1'b0;
            end
            default: begin : g_reserved
                assign w_result = '0;
                assign w_c      = 1'b0;
                assign w_v      = 1'b0;
            end
        endcase
    endgenerate

    assign w_flags[FLAG_N] = w_result[c_msb];
    assign w_flags[FLAG_Z] = (w_result == '0);
    assign w_flags[FLAG_C] = w_c;
    assign w_flags[FLAG_V] = w_v;

    // Reset clears Z too, so the held flags read all-zero rather than "result is zero".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else begin
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    assign bus.ALUResult = r_result;
    assign bus.ALUFlags  = r_flags;

endmodule : alu_unit
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_unit : one 4-bit instance per opcode plus a reserved code, driven in parallel
// Revision: 1.0
// ============================================================================
module tb_alu_unit;

    localparam int NUM_OPS = 11;  // 0..9 real opcodes, 10 reserved

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       fin = 1'b0;
    logic [3:0] res [0:NUM_OPS-1];
    logic [3:0] flg [0:NUM_OPS-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar k;
    generate
        for (k = 0; k < NUM_OPS; k++) begin : g_dut
            alu_if #(.bits(4)) bus ();
            assign bus.ALUA      = a;
            assign bus.ALUB      = b;
            assign bus.ALUFlagIn = fin;
            alu_unit #(.bits(4), .ALUControl(4'(k))) u_alu (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
            assign res[k] = bus.ALUResult;
            assign flg[k] = bus.ALUFlags;
        end
    endgenerate

    typedef struct {
        string    name;
        int       op;
        bit [3:0] a;
        bit [3:0] b;
        bit       fin;
        bit [3:0] r;
        bit [3:0] f;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int op,
                         input logic [3:0] exp_r, input logic [3:0] exp_f);
        checks++;
        if (res[op] !== exp_r || flg[op] !== exp_f) begin
            errors++;
            $display("FAIL %s: got R=%b F=%b, expected R=%b F=%b",
                     name, res[op], flg[op], exp_r, exp_f);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vf);
        @(negedge clk);
        a   = va;
        b   = vb;
        fin = vf;
    endtask

    initial begin
        vecs.push_back('{"add_ovf_cin",  0, 4'b0111, 4'b0111, 1'b1, 4'b1111, 4'b1001});
        vecs.push_back('{"add_neg_wrap", 0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b0111});
        vecs.push_back('{"add_plain",    0, 4'b0011, 4'b0100, 1'b0, 4'b0111, 4'b0000});
        vecs.push_back('{"sub_ovf",      1, 4'b0111, 4'b1001, 1'b0, 4'b1110, 4'b1011});
        vecs.push_back('{"sub_bin",      1, 4'b1000, 4'b1000, 1'b1, 4'b1111, 4'b1010});
        vecs.push_back('{"sub_plain",    1, 4'b0101, 4'b0011, 1'b1, 4'b0001, 4'b0000});
        vecs.push_back('{"inc_wrap",     2, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0110});
        vecs.push_back('{"inc_maxpos",   2, 4'b0111, 4'b0000, 1'b1, 4'b1000, 4'b1001});
        vecs.push_back('{"dec_zero",     3, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1010});
        vecs.push_back('{"dec_minneg",   3, 4'b1000, 4'b0000, 1'b0, 4'b0111, 4'b0001});
        vecs.push_back('{"and",          4, 4'b1110, 4'b1100, 1'b1, 4'b1100, 4'b1000});
        vecs.push_back('{"or",           5, 4'b1010, 4'b0101, 1'b0, 4'b1111, 4'b1000});
        vecs.push_back('{"not",          6, 4'b0011, 4'b0000, 1'b0, 4'b1100, 4'b1000});
        vecs.push_back('{"xor",          7, 4'b0000, 4'b1000, 1'b0, 4'b1000, 4'b1000});
        vecs.push_back('{"sl_big",       8, 4'b0001, 4'b0111, 1'b0, 4'b0000, 4'b0100});
        vecs.push_back('{"sl_one",       8, 4'b1100, 4'b0001, 1'b0, 4'b1000, 4'b1010});
        vecs.push_back('{"sl_eq_bits",   8, 4'b1001, 4'b0100, 1'b0, 4'b0000, 4'b0110});
        vecs.push_back('{"sl_zero",      8, 4'b0101, 4'b0000, 1'b1, 4'b0101, 4'b0000});
        vecs.push_back('{"sr_two",       9, 4'b1101, 4'b0010, 1'b0, 4'b1111, 4'b1000});
        vecs.push_back('{"sr_pos",       9, 4'b0110, 4'b0010, 1'b0, 4'b0001, 4'b0010});
        vecs.push_back('{"sr_big",       9, 4'b1010, 4'b0101, 1'b0, 4'b1111, 4'b1010});
        vecs.push_back('{"sr_zero",      9, 4'b0110, 4'b0000, 1'b0, 4'b0110, 4'b0000});
        vecs.push_back('{"reserved",    10, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0100});

        // Reset state: every instance, including reserved (Z must stay low)
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_OPS; i++)
            check($sformatf("reset_op%0d", i), i, 4'b0000, 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, one per cycle back-to-back
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].fin);
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].op, vecs[i].r, vecs[i].f);
        end

        // Latency exactly one: new inputs are not visible before the edge
        drive(4'b0001, 4'b0001, 1'b0);
        @(posedge clk); #1;
        check("lat_add_a", 0, 4'b0010, 4'b0000);
        drive(4'b0010, 4'b0011, 1'b0);
        #1;
        check("lat_hold", 0, 4'b0010, 4'b0000);
        @(posedge clk); #1;
        check("lat_add_b", 0, 4'b0101, 4'b0000);

        // Reset mid-stream discards the pending result
        drive(4'b0111, 4'b0111, 1'b1);
        @(posedge clk); #1;
        check("pre_rst", 0, 4'b1111, 4'b1001);
        drive(4'b0001, 4'b0001, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_add", 0, 4'b0000, 4'b0000);
        check("mid_rst_res", 10, 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_add", 0, 4'b0010, 4'b0000);
        check("post_rst_res", 10, 4'b0000, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_unit
`default_nettype wire
